// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO in front of the serial framer.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits.
module uart_tx_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV      = CLK_FREQ / BAUD_RATE;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int BAUD_W   = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
    localparam int IDX_W    = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
        logic even_p;
        even_p = ^word;
        if (PARITY == 32'sd2) begin
            calc_parity = ~even_p;
        end else begin
            calc_parity = even_p;
        end
    endfunction

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_nxt_s;
    logic                 ready_r;

    state_t               state_r;
    logic [BAUD_W-1:0]    baud_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r;
    logic                 tx_r;
    logic                 busy_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 has_word_s;
    logic                 bit_end_s;
    logic                 stop_end_s;
    logic [DATA_BITS-1:0] head_s;

    assign push_s     = in_valid && ready_r;
    assign has_word_s = (count_r != {CNT_W{1'b0}});
    assign bit_end_s  = (baud_r == BAUD_W'(DIV - 1));
    assign stop_end_s = (baud_r == BAUD_W'(STOP_LEN - 1));
    assign head_s     = mem_r[rd_ptr_r];

    // The framer pops the head word when leaving IDLE or when a stop period ends with data waiting.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = has_word_s;
            STOP:    pop_s = stop_end_s && has_word_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Occupancy after this edge; a simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s != CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Frame sequencer: one baud counter reused for every bit, restarted at each state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
            par_bit_r <= 1'b0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_r <= {BAUD_W{1'b0}};
                    if (has_word_s) begin
                        shift_r   <= head_s;
                        par_bit_r <= calc_parity(head_s);
                        state_r   <= START;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        baud_r    <= {BAUD_W{1'b0}};
                        bit_idx_r <= {IDX_W{1'b0}};
                        tx_r      <= shift_r[0];
                        state_r   <= DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_r <= {BAUD_W{1'b0}};
                        if (bit_idx_r == IDX_W'(DATA_BITS - 1)) begin
                            if (PARITY != 32'sd0) begin
                                tx_r    <= par_bit_r;
                                state_r <= PAR;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= STOP;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                PAR: begin
                    if (bit_end_s) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        tx_r    <= 1'b1;
                        state_r <= STOP;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (stop_end_s) begin
                        baud_r <= {BAUD_W{1'b0}};
                        if (has_word_s) begin
                            // Back-to-back frame: no idle bit between stop and the next start.
                            shift_r   <= head_s;
                            par_bit_r <= calc_parity(head_s);
                            state_r   <= START;
                            tx_r      <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    baud_r  <= {BAUD_W{1'b0}};
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = ready_r;
    assign tx_out     = tx_r;
    assign busy       = busy_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: four framings (8N1, 8E1, 8O1, 5N2) at DIV=10.
// Accepted words are scheduled into a queue; a per-cycle monitor compares the line against it.
module tb_uart_tx_cfg;

    localparam int DIV  = 10;
    localparam int NDUT = 4;
    localparam int DEPTH = 4;
    localparam int CFG_DB  [NDUT] = '{8, 8, 8, 5};
    localparam int CFG_PAR [NDUT] = '{0, 1, 2, 0};
    localparam int CFG_SB  [NDUT] = '{1, 1, 1, 2};

    typedef struct {
        int dut;
        int data;
        int start;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_v [NDUT];
    logic [7:0] in_data_v  [NDUT];
    logic       in_ready_v [NDUT];
    logic       tx_v       [NDUT];
    logic       busy_v     [NDUT];
    logic [2:0] cnt_v      [NDUT];

    frame_t sb_q[$];
    int     last_end [NDUT];
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_data(in_data_v[0]), .in_ready(in_ready_v[0]),
        .tx_out(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]));
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_data(in_data_v[1]), .in_ready(in_ready_v[1]),
        .tx_out(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]));
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_data(in_data_v[2]), .in_ready(in_ready_v[2]),
        .tx_out(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]));
    uart_tx_cfg #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_5n2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_data(in_data_v[3][4:0]), .in_ready(in_ready_v[3]),
        .tx_out(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]));

    function automatic int frame_len(input int i);
        return (1 + CFG_DB[i] + ((CFG_PAR[i] != 0) ? 1 : 0) + CFG_SB[i]) * DIV;
    endfunction

    function automatic int data_mask(input int i);
        return (1 << CFG_DB[i]) - 1;
    endfunction

    // Line level expected at a given cycle offset into a frame, built from the bit list of the frame.
    function automatic logic exp_level(input int i, input int data, input int offset);
        int b;
        int ones;
        b = offset / DIV;
        ones = 0;
        if (b == 0) return 1'b0;
        if (b <= CFG_DB[i]) return ((data >> (b - 1)) % 2) == 1;
        if (CFG_PAR[i] != 0 && b == CFG_DB[i] + 1) begin
            for (int k = 0; k < CFG_DB[i]; k++) ones += (data >> k) % 2;
            return (CFG_PAR[i] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", name, i, cyc, act, exp);
        end
    endtask

    // Record acceptances and schedule each frame: it starts one edge after acceptance,
    // but never before the previous frame of the same DUT has finished.
    always @(posedge clk) begin
        frame_t f;
        cyc++;
        if (rst) begin
            sb_q.delete();
            for (int i = 0; i < NDUT; i++) last_end[i] = 0;
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                if (in_valid_v[i] && in_ready_v[i]) begin
                    f.dut   = i;
                    f.data  = int'(in_data_v[i]) & data_mask(i);
                    f.start = (cyc + 1 > last_end[i]) ? cyc + 1 : last_end[i];
                    last_end[i] = f.start + frame_len(i);
                    sb_q.push_back(f);
                end
            end
        end
    end

    // Monitor: every falling edge, compare line, busy and FIFO status against the schedule.
    always @(negedge clk) begin
        int   hidx;
        int   occ;
        int   off;
        logic etx;
        logic ebusy;
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                check("rst_tx", i, int'(tx_v[i]), 1);
                check("rst_busy", i, int'(busy_v[i]), 0);
                check("rst_count", i, int'(cnt_v[i]), 0);
                check("rst_ready", i, int'(in_ready_v[i]), 1);
            end else begin
                hidx = -1;
                occ = 0;
                off = -1;
                for (int j = 0; j < sb_q.size(); j++) begin
                    if (sb_q[j].dut == i) begin
                        if (hidx < 0) hidx = j;
                        if (sb_q[j].start > cyc) occ++;
                    end
                end
                etx = 1'b1;
                ebusy = 1'b0;
                if (hidx >= 0 && sb_q[hidx].start <= cyc) begin
                    off = cyc - sb_q[hidx].start;
                    etx = exp_level(i, sb_q[hidx].data, off);
                    ebusy = 1'b1;
                end
                check("tx_out", i, int'(tx_v[i]), int'(etx));
                check("busy", i, int'(busy_v[i]), int'(ebusy));
                check("fifo_count", i, int'(cnt_v[i]), occ);
                check("in_ready", i, int'(in_ready_v[i]), (occ != DEPTH) ? 1 : 0);
                if (hidx >= 0 && off == frame_len(i) - 1) sb_q.delete(hidx);
            end
        end
    end

    initial begin
        int word_n [NDUT];
        int acc_n  [NDUT];
        logic prev_acc [NDUT];
        for (int i = 0; i < NDUT; i++) begin
            in_valid_v[i] = 1'b0;
            in_data_v[i]  = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single directed frames: 0x55 on 8N1, 0x07 on even/odd parity, 0x1F on 5N2.
        @(negedge clk);
        in_data_v[0] = 8'h55;
        in_data_v[1] = 8'h07;
        in_data_v[2] = 8'h07;
        in_data_v[3] = 8'h1F;
        for (int i = 0; i < NDUT; i++) in_valid_v[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) in_valid_v[i] = 1'b0;
        repeat (130) @(negedge clk);

        // Hold in_valid from idle with words 1..6; only five fit while the first frame runs.
        for (int i = 0; i < NDUT; i++) begin
            word_n[i] = 1;
            acc_n[i] = 0;
            prev_acc[i] = 1'b0;
        end
        repeat (9) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (prev_acc[i]) begin
                    word_n[i]++;
                    acc_n[i]++;
                end
                in_valid_v[i] = (word_n[i] <= 6);
                in_data_v[i]  = 8'(word_n[i]);
                prev_acc[i]   = in_valid_v[i] && in_ready_v[i];
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            check("fill_accepted", i, acc_n[i], 5);
            check("fill_count", i, int'(cnt_v[i]), 4);
            check("fill_ready", i, int'(in_ready_v[i]), 0);
            in_valid_v[i] = 1'b0;
        end
        repeat (600) @(negedge clk);

        // Random traffic, dense enough to keep the FIFOs full most of the time.
        repeat (1200) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                in_valid_v[i] = ($urandom_range(0, 99) < 30);
                in_data_v[i]  = 8'($urandom_range(0, 255) & data_mask(i));
            end
        end
        for (int i = 0; i < NDUT; i++) in_valid_v[i] = 1'b0;
        repeat (700) @(negedge clk);

        // Reset at cycle 35 of a frame with two words queued behind it.
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                in_valid_v[i] = 1'b1;
                in_data_v[i]  = 8'($urandom_range(0, 255) & data_mask(i));
            end
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) in_valid_v[i] = 1'b0;
        repeat (34) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check("async_rst_tx", i, int'(tx_v[i]), 1);
            check("async_rst_busy", i, int'(busy_v[i]), 0);
            check("async_rst_count", i, int'(cnt_v[i]), 0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // First word after reset must start one edge after acceptance.
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            in_valid_v[i] = 1'b1;
            in_data_v[i]  = 8'($urandom_range(0, 255) & data_mask(i));
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) in_valid_v[i] = 1'b0;
        repeat (150) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000: input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600: line rate in bit/s.
REQ-003 The block SHALL have parameter DATA_BITS, default 8: data bits per frame, legal values 5..9.
REQ-004 The block SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal values 1..2.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two, at least 2.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port in_valid, input, 1 bit: a write word is presented.
REQ-010 The block SHALL have port in_data, input, DATA_BITS wide: the word to transmit.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept a word.
REQ-012 The block SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-014 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of occupied FIFO entries.

Function
REQ-015 DIV SHALL equal CLK_FREQ/BAUD_RATE using integer truncation, and every bit SHALL last exactly DIV clk cycles.
REQ-016 The baud counter SHALL run only while busy and SHALL restart from 0 at the start of every frame.
REQ-017 A word SHALL be accepted on a rising clk edge where in_valid and in_ready are both high.
REQ-018 in_ready SHALL equal NOT(fifo_count == FIFO_DEPTH).
REQ-019 in_valid while full SHALL be ignored, with no FIFO change.
REQ-020 A push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-021 Data SHALL be stored and transmitted in FIFO order.
REQ-022 The FSM states SHALL be IDLE, START, DATA, PAR, STOP.
REQ-023 IDLE with fifo_count > 0 SHALL, on the next edge, pop the head word, go to START and drive tx_out low.
REQ-024 tx_out SHALL therefore fall one clk edge after a word is accepted into an empty FIFO while IDLE.
REQ-025 START SHALL drive tx_out = 0 for DIV cycles and then go to DATA.
REQ-026 DATA SHALL send DATA_BITS bits LSB first, DIV cycles each, then go to PAR if PARITY != 0, otherwise to STOP.
REQ-027 PAR SHALL send the XOR of the data bits for even parity, or its inverse for odd, for DIV cycles.
REQ-028 STOP SHALL drive tx_out = 1 for STOP_BITS*DIV cycles.
REQ-029 At the end of STOP with fifo_count > 0, the FSM SHALL pop and enter START directly with zero idle cycles; otherwise it SHALL enter IDLE.
REQ-030 The full frame length SHALL be (1 + DATA_BITS + (PARITY != 0) + STOP_BITS)*DIV cycles.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 tx_out SHALL be a registered output and SHALL be 1 in IDLE.
REQ-033 Pushes during a frame SHALL be accepted normally and SHALL NOT disturb the frame in flight.

Reset
REQ-034 While rst = 1, tx_out SHALL be 1, busy 0, in_ready 1, fifo_count 0 and the FSM in IDLE, all taking effect asynchronously.
REQ-035 Reset mid-frame SHALL abort the frame immediately and discard all FIFO contents; no partial frame SHALL resume after release.
REQ-036 The first accepted word after rst falls SHALL behave exactly as under REQ-024.

Verification (CLK_FREQ=1000, BAUD_RATE=100, so DIV=10)
REQ-037 8N1, accept 0x55 at edge k -> tx_out low from edge k+1, then 1,0,1,0,1,0,1,0 (LSB first), 10 cycles each, then high; busy high for exactly 100 cycles.
REQ-038 PARITY=1, send 0x07 -> parity bit 1; PARITY=2, send 0x07 -> parity bit 0; both frames last 110 cycles.
REQ-039 FIFO_DEPTH=4, in_valid held high from idle with words 0x01..0x06 -> five words accepted, fifo_count=4, in_ready=0; five frames sent back-to-back with no idle cycle, in order 0x01..0x05.
REQ-040 DATA_BITS=5, STOP_BITS=2, PARITY=0, send 0x1F -> frame 0,1,1,1,1,1,1,1 lasting 80 cycles, then busy=0.
REQ-041 Assert rst at cycle 35 of a frame with 2 words queued -> tx_out=1, busy=0, fifo_count=0 at once; after release no output until a new word is accepted.
